// File: rtl/cnn_mem_pkg.sv
// Shared constants, bank indices and clear-engine state type for the CNN
// feature/weight store.
package cnn_mem_pkg;

    // Default geometry: one 28x28 picture times a 3x3 kernel window.
    localparam int PICTURE_SIZE  = 28;
    localparam int DEF_NUM_BANKS = 3;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_DEPTH     = PICTURE_SIZE * PICTURE_SIZE * 9;

    // Conventional bank assignment.
    localparam int BANK_PIX  = 0;
    localparam int BANK_TPIX = 1;
    localparam int BANK_WEI  = 2;

    // Clear engine states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

    // Width of an index that can count 0..depth-1 (at least one bit).
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/cnn_ram_bank.sv
// Single synchronous RAM bank: one write port, one read port, optional
// write-to-read forwarding and a 1- or 2-cycle registered read path.
//
// Read handshake: rd_en sampled high at edge N is a request that cannot be
// refused; rd_valid is high for exactly one cycle, RD_LAT cycles later, and
// rd_data is the matching word in that cycle. rd_data holds otherwise.
module cnn_ram_bank
    import cnn_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int RD_LAT = 1,
    parameter int WR_FWD = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic signed [DATA_W-1:0] rd_data,
    output logic                     rd_valid
);

    localparam int IDX_W = idx_width(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic signed [DATA_W-1:0] mem [DEPTH];

    logic                     wr_ok;
    logic                     rd_ok;
    logic                     fwd_hit;
    logic signed [DATA_W-1:0] rd_word;
    logic signed [DATA_W-1:0] data_q1;
    logic                     valid_q1;

    assign wr_ok   = ({1'b0, wr_addr} < DEPTH_L);
    assign rd_ok   = ({1'b0, rd_addr} < DEPTH_L);
    assign fwd_hit = (WR_FWD != 0) && wr_en && wr_ok && (wr_addr == rd_addr);

    // Storage: out-of-range writes are discarded, contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en && wr_ok) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    // Word presented to the first read register: zero when out of range,
    // the incoming write data on a forwarded collision, else the stored word.
    always_comb begin
        rd_word = '0;
        if (!rd_ok) begin
            rd_word = '0;
        end else if (fwd_hit) begin
            rd_word = wr_data;
        end else begin
            rd_word = mem[rd_addr[IDX_W-1:0]];
        end
    end

    // First read stage: capture on request, hold data between requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q1  <= '0;
            valid_q1 <= 1'b0;
        end else begin
            valid_q1 <= rd_en;
            if (rd_en) begin
                data_q1 <= rd_word;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic signed [DATA_W-1:0] data_q2;
            logic                     valid_q2;

            // Extra output register stage; data only moves with a valid word.
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_q2  <= '0;
                    valid_q2 <= 1'b0;
                end else begin
                    valid_q2 <= valid_q1;
                    if (valid_q1) begin
                        data_q2 <= data_q1;
                    end
                end
            end

            assign rd_data  = data_q2;
            assign rd_valid = valid_q2;
        end else begin : g_lat1
            assign rd_data  = data_q1;
            assign rd_valid = valid_q1;
        end
    endgenerate

endmodule

// File: rtl/cnn_bank_ram.sv
// Multi-bank feature/weight store with a hardware bank-clear engine and a
// sticky out-of-range flag. Each bank is an independent cnn_ram_bank.
module cnn_bank_ram
    import cnn_mem_pkg::*;
#(
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int RD_LAT    = 1,
    parameter int WR_FWD    = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_BANKS-1:0]        wr_en,
    input  logic [NUM_BANKS*ADDR_W-1:0] wr_addr,
    input  logic [NUM_BANKS*DATA_W-1:0] wr_data,
    input  logic [NUM_BANKS-1:0]        rd_en,
    input  logic [NUM_BANKS*ADDR_W-1:0] rd_addr,
    output logic [NUM_BANKS*DATA_W-1:0] rd_data,
    output logic [NUM_BANKS-1:0]        rd_valid,
    input  logic                        clr_start,
    input  logic [NUM_BANKS-1:0]        clr_mask,
    output logic                        clr_busy,
    output logic                        clr_done,
    output logic                        oor_err
);

    localparam int CNT_W = idx_width(DEPTH);
    localparam logic [CNT_W-1:0]  LAST    = CNT_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

    clr_state_e           state;
    logic [CNT_W-1:0]     cnt;
    logic [NUM_BANKS-1:0] mask_q;

    logic [NUM_BANKS-1:0] bank_we;
    logic [ADDR_W-1:0]    bank_wa [NUM_BANKS];
    logic [DATA_W-1:0]    bank_wd [NUM_BANKS];
    logic                 oor_hit;

    // Clear engine: sweeps counter 0..DEPTH-1 over the latched mask, then
    // emits one clr_done pulse. A zero mask goes straight to the pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            mask_q   <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    clr_done <= 1'b0;
                    if (clr_start) begin
                        if (|clr_mask) begin
                            mask_q   <= clr_mask;
                            cnt      <= '0;
                            clr_busy <= 1'b1;
                            state    <= CLEAR;
                        end else begin
                            clr_done <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                CLEAR: begin
                    if (cnt == LAST) begin
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    clr_done <= 1'b0;
                    cnt      <= '0;
                    state    <= IDLE;
                end
                default: begin
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Per-bank write port: the clear engine owns masked banks while clearing,
    // and nothing is written on a reset edge.
    always_comb begin
        bank_we = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_wa[b] = wr_addr[b*ADDR_W +: ADDR_W];
            bank_wd[b] = wr_data[b*DATA_W +: DATA_W];
            if (state == CLEAR && mask_q[b]) begin
                bank_we[b] = !rst;
                bank_wa[b] = ADDR_W'(cnt);
                bank_wd[b] = '0;
            end else begin
                bank_we[b] = !rst && wr_en[b];
            end
        end
    end

    // Any external access beyond the last word raises the error flag.
    always_comb begin
        oor_hit = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (wr_en[b] && ({1'b0, wr_addr[b*ADDR_W +: ADDR_W]} >= DEPTH_L)) begin
                oor_hit = 1'b1;
            end
            if (rd_en[b] && ({1'b0, rd_addr[b*ADDR_W +: ADDR_W]} >= DEPTH_L)) begin
                oor_hit = 1'b1;
            end
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            oor_err <= 1'b0;
        end else if (oor_hit) begin
            oor_err <= 1'b1;
        end
    end

    generate
        for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
            cnn_ram_bank #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W),
                .DEPTH  (DEPTH),
                .RD_LAT (RD_LAT),
                .WR_FWD (WR_FWD)
            ) u_bank (
                .clk      (clk),
                .rst      (rst),
                .wr_en    (bank_we[g]),
                .wr_addr  (bank_wa[g]),
                .wr_data  (bank_wd[g]),
                .rd_en    (rd_en[g]),
                .rd_addr  (rd_addr[g*ADDR_W +: ADDR_W]),
                .rd_data  (rd_data[g*DATA_W +: DATA_W]),
                .rd_valid (rd_valid[g])
            );
        end
    endgenerate

endmodule

// File: tb/tb_cnn_bank_ram.sv
// Bench for cnn_bank_ram: two instances share one stimulus stream, one with
// RD_LAT=1/WR_FWD=0 (a_*) and one with RD_LAT=2/WR_FWD=1 (b_*), both DEPTH=64.
module tb_cnn_bank_ram;

  localparam int NB = 3;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int D  = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NB-1:0]    wr_en = '0;
  logic [NB*AW-1:0] wr_addr = '0;
  logic [NB*DW-1:0] wr_data = '0;
  logic [NB-1:0]    rd_en = '0;
  logic [NB*AW-1:0] rd_addr = '0;
  logic             clr_start = 1'b0;
  logic [NB-1:0]    clr_mask = '0;

  logic [NB*DW-1:0] a_rd_data, b_rd_data;
  logic [NB-1:0]    a_rd_valid, b_rd_valid;
  logic             a_clr_busy, b_clr_busy, a_clr_done, b_clr_done, a_oor_err, b_oor_err;

  cnn_bank_ram #(.NUM_BANKS(NB), .DATA_W(DW), .ADDR_W(AW), .DEPTH(D), .RD_LAT(1), .WR_FWD(0)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .clr_start(clr_start), .clr_mask(clr_mask), .clr_busy(a_clr_busy),
    .clr_done(a_clr_done), .oor_err(a_oor_err));

  cnn_bank_ram #(.NUM_BANKS(NB), .DATA_W(DW), .ADDR_W(AW), .DEPTH(D), .RD_LAT(2), .WR_FWD(1)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .clr_start(clr_start), .clr_mask(clr_mask), .clr_busy(b_clr_busy),
    .clr_done(b_clr_done), .oor_err(b_oor_err));

  // ---------------- stimulus for the next cycle ----------------
  logic [NB-1:0] t_we, t_re, t_mask;
  int            t_wa [NB];
  int            t_ra [NB];
  logic [DW-1:0] t_wd [NB];
  logic          t_start;

  // ---------------- reference model ----------------
  logic [DW-1:0] m_mem [NB][D];
  logic [DW-1:0] exp_a_d [NB];
  logic [DW-1:0] exp_b_d [NB];
  logic [DW-1:0] pipe_d  [NB];
  logic [NB-1:0] exp_a_v, exp_b_v, pipe_v, m_mask;
  logic          m_busy, m_done, m_oor;
  int            m_ptr;

  int errors = 0;
  int checks = 0;
  int busy_seen = 0;
  int done_seen = 0;

  typedef struct {
    int          bank;
    bit          we;
    int          waddr;
    logic [15:0] wdata;
    bit          re;
    int          raddr;
    bit          exp_v;
    logic [15:0] exp_d;
  } vec_t;

  vec_t tbl [10];

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [NB*DW-1:0] ead, ebd;
    for (int b = 0; b < NB; b++) begin
      ead[b*DW +: DW] = exp_a_d[b];
      ebd[b*DW +: DW] = exp_b_d[b];
    end
    check("a_rd_data", 64'(a_rd_data), 64'(ead));
    check("a_rd_valid", 64'(a_rd_valid), 64'(exp_a_v));
    check("b_rd_data", 64'(b_rd_data), 64'(ebd));
    check("b_rd_valid", 64'(b_rd_valid), 64'(exp_b_v));
    check("a_clr_busy", 64'(a_clr_busy), 64'(m_busy));
    check("b_clr_busy", 64'(b_clr_busy), 64'(m_busy));
    check("a_clr_done", 64'(a_clr_done), 64'(m_done));
    check("b_clr_done", 64'(b_clr_done), 64'(m_done));
    check("a_oor_err", 64'(a_oor_err), 64'(m_oor));
    check("b_oor_err", 64'(b_oor_err), 64'(m_oor));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    t_we = '0; t_re = '0; t_start = 1'b0; t_mask = '0;
    for (int b = 0; b < NB; b++) begin
      t_wa[b] = 0; t_ra[b] = 0; t_wd[b] = '0;
    end
  endtask

  task automatic drive();
    for (int b = 0; b < NB; b++) begin
      wr_addr[b*AW +: AW] = AW'(t_wa[b]);
      rd_addr[b*AW +: AW] = AW'(t_ra[b]);
      wr_data[b*DW +: DW] = t_wd[b];
    end
    wr_en = t_we; rd_en = t_re; clr_start = t_start; clr_mask = t_mask;
  endtask

  // One clock: model what the edge does, clock it, compare, go idle.
  task automatic step();
    logic [NB-1:0] ew;
    int            ewa [NB];
    logic [DW-1:0] ewd [NB];
    logic [DW-1:0] v_old, v_new;
    logic          done_n;
    drive();
    for (int b = 0; b < NB; b++) begin
      ew[b] = 1'b0; ewa[b] = 0; ewd[b] = '0;
      if (m_busy && m_mask[b]) begin
        ew[b] = 1'b1; ewa[b] = m_ptr; ewd[b] = '0;
      end else if (t_we[b] && t_wa[b] < D) begin
        ew[b] = 1'b1; ewa[b] = t_wa[b]; ewd[b] = t_wd[b];
      end
      if ((t_we[b] && t_wa[b] >= D) || (t_re[b] && t_ra[b] >= D)) m_oor = 1'b1;
      v_old = '0; v_new = '0;
      if (t_re[b] && t_ra[b] < D) begin
        v_old = m_mem[b][t_ra[b]];
        v_new = (ew[b] && ewa[b] == t_ra[b]) ? ewd[b] : v_old;
      end
      exp_a_v[b] = t_re[b];
      if (t_re[b]) exp_a_d[b] = v_old;
      exp_b_v[b] = pipe_v[b];
      if (pipe_v[b]) exp_b_d[b] = pipe_d[b];
      pipe_v[b] = t_re[b];
      if (t_re[b]) pipe_d[b] = v_new;
      if (ew[b]) m_mem[b][ewa[b]] = ewd[b];
    end
    done_n = 1'b0;
    if (m_busy) begin
      m_ptr++;
      if (m_ptr == D) begin
        m_busy = 1'b0; done_n = 1'b1;
      end
    end else if (!m_done && t_start) begin
      if (t_mask != '0) begin
        m_busy = 1'b1; m_ptr = 0; m_mask = t_mask;
      end else begin
        done_n = 1'b1;
      end
    end
    m_done = done_n;
    @(posedge clk);
    #1;
    compare_all();
    if (a_clr_busy) busy_seen++;
    if (a_clr_done) done_seen++;
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    drive();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_a_v = '0; exp_b_v = '0; pipe_v = '0;
    for (int b = 0; b < NB; b++) begin
      exp_a_d[b] = '0; exp_b_d[b] = '0; pipe_d[b] = '0;
    end
    m_busy = 1'b0; m_done = 1'b0; m_oor = 1'b0; m_ptr = 0; m_mask = '0;
    compare_all();
  endtask

  task automatic fill(input logic [NB-1:0] banks, input bit rnd, input logic [DW-1:0] val);
    for (int a = 0; a < D; a++) begin
      for (int b = 0; b < NB; b++) begin
        if (banks[b]) begin
          t_we[b] = 1'b1; t_wa[b] = a;
          t_wd[b] = rnd ? DW'($urandom) : val;
        end
      end
      step();
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    tbl[0] = '{0, 1, 5,  16'h7FFF, 0, 0,  0, 16'h0000};
    tbl[1] = '{0, 0, 0,  16'h0000, 1, 5,  1, 16'h7FFF};
    tbl[2] = '{2, 1, 10, 16'h0042, 0, 0,  0, 16'h0000};
    tbl[3] = '{2, 1, 10, 16'h1234, 1, 10, 1, 16'h0042};
    tbl[4] = '{2, 0, 0,  16'h0000, 1, 10, 1, 16'h1234};
    tbl[5] = '{1, 1, 0,  16'h8000, 0, 0,  0, 16'h0000};
    tbl[6] = '{1, 0, 0,  16'h0000, 1, 0,  1, 16'h8000};
    tbl[7] = '{0, 1, 0,  16'h0101, 0, 0,  0, 16'h0000};
    tbl[8] = '{0, 1, 64, 16'h5555, 1, 64, 1, 16'h0000};
    tbl[9] = '{0, 0, 0,  16'h0000, 1, 0,  1, 16'h0101};

    do_reset();

    // Directed vectors on the RD_LAT=1 / WR_FWD=0 instance.
    for (int i = 0; i < 10; i++) begin
      t_we[tbl[i].bank] = tbl[i].we;
      t_wa[tbl[i].bank] = tbl[i].waddr;
      t_wd[tbl[i].bank] = tbl[i].wdata;
      t_re[tbl[i].bank] = tbl[i].re;
      t_ra[tbl[i].bank] = tbl[i].raddr;
      step();
      check("tbl_valid", 64'(a_rd_valid[tbl[i].bank]), 64'(tbl[i].exp_v));
      if (tbl[i].exp_v) check("tbl_data", 64'(a_rd_data[tbl[i].bank*DW +: DW]), 64'(tbl[i].exp_d));
    end
    for (int i = 0; i < 3; i++) step();
    check("oor_sticky", 64'(a_oor_err), 64'd1);
    do_reset();
    check("oor_after_rst", 64'(a_oor_err), 64'd0);

    // Streaming on the RD_LAT=2 instance.
    for (int a = 0; a < 4; a++) begin
      t_we[0] = 1'b1; t_wa[0] = a; t_wd[0] = DW'(10 + a);
      step();
    end
    for (int k = 0; k < 7; k++) begin
      bit ev;
      if (k < 4) begin
        t_re[0] = 1'b1; t_ra[0] = k;
      end
      step();
      ev = (k >= 1 && k <= 4);
      check("stream_valid", 64'(b_rd_valid[0]), 64'(ev));
      if (ev) check("stream_data", 64'(b_rd_data[DW-1:0]), 64'(10 + k - 1));
    end

    // Clear of banks 0 and 2 with writes and reads during the sweep.
    fill('1, 1'b0, 16'hAAAA);
    busy_seen = 0; done_seen = 0;
    t_start = 1'b1; t_mask = 3'b101;
    step();
    for (int i = 0; i < 100 && done_seen == 0; i++) begin
      if (i == 30) begin
        t_we[0] = 1'b1; t_wa[0] = 5; t_wd[0] = 16'h1111;
        t_we[1] = 1'b1; t_wa[1] = 5; t_wd[1] = 16'h2222;
      end
      if (i == 40) begin
        t_start = 1'b1; t_mask = 3'b010;
      end
      for (int b = 0; b < NB; b++) begin
        t_re[b] = 1'($urandom_range(0, 1)); t_ra[b] = $urandom_range(0, D - 1);
      end
      step();
    end
    for (int i = 0; i < 3; i++) step();
    check("clr_busy_cycles", 64'(busy_seen), 64'd64);
    check("clr_done_pulses", 64'(done_seen), 64'd1);
    for (int a = 0; a < D; a++) begin
      t_re = '1; t_ra[0] = a; t_ra[1] = a; t_ra[2] = a;
      step();
      check("clr_bank0", 64'(a_rd_data[0*DW +: DW]), 64'd0);
      check("clr_bank1", 64'(a_rd_data[1*DW +: DW]), (a == 5) ? 64'h2222 : 64'hAAAA);
      check("clr_bank2", 64'(a_rd_data[2*DW +: DW]), 64'd0);
    end

    // Zero mask: a lone done pulse, never busy.
    t_start = 1'b1; t_mask = '0;
    step();
    check("zero_mask_done", 64'(a_clr_done), 64'd1);
    check("zero_mask_busy", 64'(a_clr_busy), 64'd0);
    step();

    // Reset in the middle of a clear.
    fill(3'b001, 1'b0, 16'h5A5A);
    t_start = 1'b1; t_mask = 3'b001;
    step();
    for (int i = 0; i < 20; i++) step();
    done_seen = 0;
    do_reset();
    check("rst_mid_busy", 64'(a_clr_busy), 64'd0);
    for (int i = 0; i < 3; i++) step();
    check("rst_mid_no_done", 64'(done_seen), 64'd0);
    for (int a = 0; a < D; a++) begin
      t_re[0] = 1'b1; t_ra[0] = a;
      step();
      check("rst_mid_data", 64'(a_rd_data[DW-1:0]), (a < 20) ? 64'd0 : 64'h5A5A);
    end

    // Randomized traffic against the model.
    fill('1, 1'b1, '0);
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < NB; b++) begin
        t_we[b] = 1'($urandom_range(0, 1)); t_wa[b] = $urandom_range(0, D + 3);
        t_wd[b] = DW'($urandom);
        t_re[b] = 1'($urandom_range(0, 1)); t_ra[b] = $urandom_range(0, D + 3);
      end
      if ($urandom_range(0, 199) == 0) begin
        t_start = 1'b1; t_mask = NB'($urandom_range(0, 7));
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
